// File: rtl/div_pipe8_pkg.sv
// Shared constants, stage record layout and busy-tag helper for the
// 8-stage RV32M divider.
package div_pipe8_pkg;

  localparam int DIV_XLEN       = 32;
  localparam int DIV_BPS        = 4;
  localparam int DIV_STAGES     = 8;
  localparam int RD_W           = 5;
  localparam int BUSY_W         = 7;
  localparam int BUSY_VALID_BIT = 6;
  localparam int BUSY_REM_BIT   = 5;
  localparam int BUSY_RD_MSB    = 4;
  localparam int BUSY_RD_LSB    = 0;

  // One pipeline slot: control/metadata plus the partial magnitude state.
  // dvd holds the dividend bits not yet shifted into rem, MSB-aligned.
  typedef struct packed {
    logic                valid;
    logic                get_rem;
    logic                neg_q;
    logic                neg_r;
    logic                div0;
    logic [RD_W-1:0]     rd;
    logic [DIV_XLEN-1:0] rem;
    logic [DIV_XLEN-1:0] quo;
    logic [DIV_XLEN-1:0] divisor;
    logic [DIV_XLEN-1:0] dvd;
  } div_stage_t;

  // Busy tag seen by decode: {valid, get_rem, rd}, all-zero for a bubble.
  function automatic logic [BUSY_W-1:0] busy_tag(input div_stage_t s);
    logic [BUSY_W-1:0] t;
    t = '0;
    if (s.valid) begin
      t[BUSY_VALID_BIT]            = 1'b1;
      t[BUSY_REM_BIT]              = s.get_rem;
      t[BUSY_RD_MSB:BUSY_RD_LSB]   = s.rd;
    end
    return t;
  endfunction

endpackage

// File: rtl/div_pipe8_if.sv
// Issue / busy-tag / writeback bundle between decode-execute and the divider.
interface div_pipe8_if
  import div_pipe8_pkg::*;
#(
  parameter int XLEN = 32
);

  logic              issue_valid;
  logic              issue_signed;
  logic              issue_get_rem;
  logic [RD_W-1:0]   issue_rd;
  logic [XLEN-1:0]   issue_dividend;
  logic [XLEN-1:0]   issue_divisor;

  logic [BUSY_W-1:0] div_busy_0;
  logic [BUSY_W-1:0] div_busy_1;
  logic [BUSY_W-1:0] div_busy_2;
  logic [BUSY_W-1:0] div_busy_3;
  logic [BUSY_W-1:0] div_busy_4;
  logic [BUSY_W-1:0] div_busy_5;
  logic [BUSY_W-1:0] div_busy_6;
  logic [BUSY_W-1:0] div_busy_7;

  logic              wb_valid;
  logic [RD_W-1:0]   wb_rd;
  logic [XLEN-1:0]   wb_data;

  // Decode side: issues ops, watches tags and writeback.
  modport master (
    output issue_valid, issue_signed, issue_get_rem, issue_rd,
           issue_dividend, issue_divisor,
    input  div_busy_0, div_busy_1, div_busy_2, div_busy_3,
           div_busy_4, div_busy_5, div_busy_6, div_busy_7,
           wb_valid, wb_rd, wb_data
  );

  // Divider side.
  modport slave (
    input  issue_valid, issue_signed, issue_get_rem, issue_rd,
           issue_dividend, issue_divisor,
    output div_busy_0, div_busy_1, div_busy_2, div_busy_3,
           div_busy_4, div_busy_5, div_busy_6, div_busy_7,
           wb_valid, wb_rd, wb_data
  );

endinterface

// File: rtl/div_pipe8_div_stage_step.sv
// Combinational unrolled restoring-division step: resolves BITS_PER_STAGE
// quotient bits from the magnitude operands.
module div_stage_step
  import div_pipe8_pkg::*;
#(
  parameter int XLEN           = DIV_XLEN,
  parameter int BITS_PER_STAGE = DIV_BPS
) (
  input  logic [XLEN-1:0] i_rem,
  input  logic [XLEN-1:0] i_quo,
  input  logic [XLEN-1:0] i_dvd,
  input  logic [XLEN-1:0] i_divisor,
  output logic [XLEN-1:0] o_rem,
  output logic [XLEN-1:0] o_quo,
  output logic [XLEN-1:0] o_dvd
);

  logic [XLEN-1:0] w_rem;
  logic [XLEN-1:0] w_quo;
  logic [XLEN-1:0] w_dvd;
  logic [XLEN-1:0] w_low;
  logic [XLEN-1:0] w_sub;
  logic            w_top;
  logic            w_borrow;
  logic            w_ge;

  // Shift in the next dividend bit, trial-subtract, keep the difference on no borrow.
  // The shifted-out rem MSB (w_top) makes the trial value XLEN+1 bits wide.
  always_comb begin
    w_rem    = i_rem;
    w_quo    = i_quo;
    w_dvd    = i_dvd;
    w_low    = '0;
    w_sub    = '0;
    w_top    = 1'b0;
    w_borrow = 1'b0;
    w_ge     = 1'b0;
    for (int i = 0; i < BITS_PER_STAGE; i++) begin
      w_top             = w_rem[XLEN-1];
      w_low             = {w_rem[XLEN-2:0], w_dvd[XLEN-1]};
      w_dvd             = {w_dvd[XLEN-2:0], 1'b0};
      {w_borrow, w_sub} = {1'b0, w_low} - {1'b0, i_divisor};
      w_ge              = w_top | ~w_borrow;
      w_rem             = w_ge ? w_sub : w_low;
      w_quo             = {w_quo[XLEN-2:0], w_ge};
    end
  end

  assign o_rem = w_rem;
  assign o_quo = w_quo;
  assign o_dvd = w_dvd;

endmodule

// File: rtl/div_pipe8.sv
// Fully pipelined 8-stage RV32M divider (DIV/DIVU/REM/REMU). One op per
// cycle in, each result out exactly 8 cycles later; every stage exports a
// busy tag for decode's RAW and writeback-collision stalls.
module div_pipe8
  import div_pipe8_pkg::*;
#(
  parameter int XLEN           = 32,
  parameter int BITS_PER_STAGE = 4
) (
  input logic         clk,
  input logic         rst,
  div_pipe8_if.slave  div_bus
);

  logic            w_neg_a;
  logic            w_neg_b;
  logic [XLEN-1:0] w_abs_a;
  logic [XLEN-1:0] w_abs_b;

  logic [XLEN-1:0] w_srem [DIV_STAGES];
  logic [XLEN-1:0] w_squo [DIV_STAGES];
  logic [XLEN-1:0] w_sdvd [DIV_STAGES];

  div_stage_t      w_nxt  [DIV_STAGES];
  div_stage_t      r_stg  [DIV_STAGES];

  logic [XLEN-1:0] w_quo_res;
  logic [XLEN-1:0] w_rem_res;

  // Two's-complement sign correction of a magnitude result.
  function automatic logic [XLEN-1:0] f_sign_fix(input logic neg,
                                                 input logic [XLEN-1:0] mag);
    return neg ? (~mag + 1'b1) : mag;
  endfunction

  assign w_neg_a = div_bus.issue_signed & div_bus.issue_dividend[XLEN-1];
  assign w_neg_b = div_bus.issue_signed & div_bus.issue_divisor[XLEN-1];
  assign w_abs_a = f_sign_fix(w_neg_a, div_bus.issue_dividend);
  assign w_abs_b = f_sign_fix(w_neg_b, div_bus.issue_divisor);

  genvar k;
  generate
    for (k = 0; k < DIV_STAGES; k++) begin : g_stage
      if (k == 0) begin : g_issue
        div_stage_step #(
          .XLEN           (XLEN),
          .BITS_PER_STAGE (BITS_PER_STAGE)
        ) u_step (
          .i_rem     ('0),
          .i_quo     ('0),
          .i_dvd     (w_abs_a),
          .i_divisor (w_abs_b),
          .o_rem     (w_srem[k]),
          .o_quo     (w_squo[k]),
          .o_dvd     (w_sdvd[k])
        );

        assign w_nxt[k] = '{
          valid:   div_bus.issue_valid,
          get_rem: div_bus.issue_get_rem,
          neg_q:   div_bus.issue_signed
                   & (div_bus.issue_dividend[XLEN-1] ^ div_bus.issue_divisor[XLEN-1])
                   & (div_bus.issue_divisor != '0),
          neg_r:   w_neg_a,
          div0:    (div_bus.issue_divisor == '0),
          rd:      div_bus.issue_rd,
          rem:     w_srem[k],
          quo:     w_squo[k],
          divisor: w_abs_b,
          dvd:     w_sdvd[k]
        };
      end else begin : g_mid
        div_stage_step #(
          .XLEN           (XLEN),
          .BITS_PER_STAGE (BITS_PER_STAGE)
        ) u_step (
          .i_rem     (r_stg[k-1].rem),
          .i_quo     (r_stg[k-1].quo),
          .i_dvd     (r_stg[k-1].dvd),
          .i_divisor (r_stg[k-1].divisor),
          .o_rem     (w_srem[k]),
          .o_quo     (w_squo[k]),
          .o_dvd     (w_sdvd[k])
        );

        assign w_nxt[k] = '{
          valid:   r_stg[k-1].valid,
          get_rem: r_stg[k-1].get_rem,
          neg_q:   r_stg[k-1].neg_q,
          neg_r:   r_stg[k-1].neg_r,
          div0:    r_stg[k-1].div0,
          rd:      r_stg[k-1].rd,
          rem:     w_srem[k],
          quo:     w_squo[k],
          divisor: r_stg[k-1].divisor,
          dvd:     w_sdvd[k]
        };
      end
    end
  endgenerate

  // Stage boundaries _p0.._p7: every slot advances each cycle, bubbles included;
  // reset only clears the valid bits, the datapath is don't-care when invalid.
  always_ff @(posedge clk) begin
    for (int s = 0; s < DIV_STAGES; s++) begin
      r_stg[s] <= w_nxt[s];
      if (rst) begin
        r_stg[s].valid <= 1'b0;
      end
    end
  end

  assign div_bus.div_busy_0 = busy_tag(r_stg[0]);
  assign div_bus.div_busy_1 = busy_tag(r_stg[1]);
  assign div_bus.div_busy_2 = busy_tag(r_stg[2]);
  assign div_bus.div_busy_3 = busy_tag(r_stg[3]);
  assign div_bus.div_busy_4 = busy_tag(r_stg[4]);
  assign div_bus.div_busy_5 = busy_tag(r_stg[5]);
  assign div_bus.div_busy_6 = busy_tag(r_stg[6]);
  assign div_bus.div_busy_7 = busy_tag(r_stg[7]);

  // Writeback result from the last stage: divide-by-zero forces all-ones quotient,
  // overflow and zero-remainder cases fall out of the magnitude datapath.
  always_comb begin
    w_quo_res = r_stg[DIV_STAGES-1].div0 ? '1
              : f_sign_fix(r_stg[DIV_STAGES-1].neg_q, r_stg[DIV_STAGES-1].quo);
    w_rem_res = f_sign_fix(r_stg[DIV_STAGES-1].neg_r, r_stg[DIV_STAGES-1].rem);
  end

  assign div_bus.wb_valid = r_stg[DIV_STAGES-1].valid;
  assign div_bus.wb_rd    = r_stg[DIV_STAGES-1].valid ? r_stg[DIV_STAGES-1].rd : '0;
  assign div_bus.wb_data  = !r_stg[DIV_STAGES-1].valid ? '0
                          : (r_stg[DIV_STAGES-1].get_rem ? w_rem_res : w_quo_res);

endmodule

// File: tb/tb_div_pipe8.sv
// Testbench for div_pipe8: table-driven vectors and random ops checked by a
// scoreboard at writeback, plus hand sequences for tags, gaps and reset.
module tb_div_pipe8;
  import div_pipe8_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  div_pipe8_if #(.XLEN(32)) bus ();

  div_pipe8 #(.XLEN(32), .BITS_PER_STAGE(4)) dut (
    .clk     (clk),
    .rst     (rst),
    .div_bus (bus)
  );

  typedef struct {
    logic        sgn;
    logic        gr;
    logic [4:0]  rd;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
  } vec_t;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
    int          due;
  } sb_t;

  sb_t  sb[$];
  sb_t  mon_e;
  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;
  bit   mon_en   = 1'b0;

  logic [6:0] busy [8];
  assign busy[0] = bus.div_busy_0;
  assign busy[1] = bus.div_busy_1;
  assign busy[2] = bus.div_busy_2;
  assign busy[3] = bus.div_busy_3;
  assign busy[4] = bus.div_busy_4;
  assign busy[5] = bus.div_busy_5;
  assign busy[6] = bus.div_busy_6;
  assign busy[7] = bus.div_busy_7;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] ref_div(input logic sgn, input logic gr,
                                          input logic [31:0] a, input logic [31:0] b);
    logic [31:0] q, r;
    if (b == 32'd0) begin
      q = 32'hFFFF_FFFF; r = a;
    end else if (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      q = a; r = 32'd0;
    end else if (sgn) begin
      q = $signed(a) / $signed(b);
      r = $signed(a) % $signed(b);
    end else begin
      q = a / b;
      r = a % b;
    end
    return gr ? r : q;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Writeback monitor: every expected result must appear exactly on its due cycle.
  always @(negedge clk) begin
    if (mon_en) begin
      if (sb.size() > 0 && sb[0].due == cyc) begin
        mon_e = sb.pop_front();
        chk("wb_valid", {31'b0, bus.wb_valid}, 32'd1);
        chk("wb_rd", {27'b0, bus.wb_rd}, {27'b0, mon_e.rd});
        chk("wb_data", bus.wb_data, mon_e.data);
      end else if (bus.wb_valid !== 1'b0) begin
        chk("wb_unexpected", {31'b0, bus.wb_valid}, 32'd0);
      end
    end
  end

  task automatic issue(input logic sgn, input logic gr, input logic [4:0] rd,
                       input logic [31:0] a, input logic [31:0] b, input logic [31:0] exp);
    @(negedge clk); #1;
    bus.issue_valid    = 1'b1;
    bus.issue_signed   = sgn;
    bus.issue_get_rem  = gr;
    bus.issue_rd       = rd;
    bus.issue_dividend = a;
    bus.issue_divisor  = b;
    sb.push_back('{rd: rd, data: exp, due: cyc + 8});
  endtask

  task automatic idle();
    @(negedge clk); #1;
    bus.issue_valid = 1'b0;
  endtask

  task automatic drain();
    idle();
    for (int n = 0; n < 20 && sb.size() > 0; n++) @(posedge clk);
    @(negedge clk); #1;
    chk("drain_pending", sb.size(), 32'd0);
  endtask

  vec_t tbl[15];
  int   ntag;
  logic [31:0] ra, rb;
  logic        rs, rg;

  initial begin
    tbl[0]  = '{1'b0, 1'b0, 5'd5,  32'd100,        32'd7,          32'd14};
    tbl[1]  = '{1'b0, 1'b1, 5'd5,  32'd100,        32'd7,          32'd2};
    tbl[2]  = '{1'b1, 1'b0, 5'd3,  32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD};
    tbl[3]  = '{1'b1, 1'b1, 5'd4,  32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFF};
    tbl[4]  = '{1'b1, 1'b1, 5'd6,  32'd7,          32'hFFFF_FFFE,  32'd1};
    tbl[5]  = '{1'b1, 1'b0, 5'd7,  32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000};
    tbl[6]  = '{1'b1, 1'b1, 5'd8,  32'h8000_0000,  32'hFFFF_FFFF,  32'd0};
    tbl[7]  = '{1'b0, 1'b0, 5'd9,  32'd123,        32'd0,          32'hFFFF_FFFF};
    tbl[8]  = '{1'b0, 1'b1, 5'd10, 32'd123,        32'd0,          32'd123};
    tbl[9]  = '{1'b1, 1'b0, 5'd11, 32'hFFFF_FFFB,  32'd0,          32'hFFFF_FFFF};
    tbl[10] = '{1'b1, 1'b1, 5'd12, 32'hFFFF_FFFB,  32'd0,          32'hFFFF_FFFB};
    tbl[11] = '{1'b0, 1'b0, 5'd13, 32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF};
    tbl[12] = '{1'b1, 1'b0, 5'd14, 32'd7,          32'hFFFF_FFFE,  32'hFFFF_FFFD};
    tbl[13] = '{1'b0, 1'b0, 5'd0,  32'h8000_0000,  32'd3,          32'h2AAA_AAAA};
    tbl[14] = '{1'b0, 1'b1, 5'd31, 32'h8000_0000,  32'd3,          32'd2};

    bus.issue_valid    = 1'b0;
    bus.issue_signed   = 1'b0;
    bus.issue_get_rem  = 1'b0;
    bus.issue_rd       = '0;
    bus.issue_dividend = '0;
    bus.issue_divisor  = '0;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int k = 0; k < 8; k++) chk($sformatf("reset_busy%0d", k), {25'b0, busy[k]}, 32'd0);
    chk("reset_wb_valid", {31'b0, bus.wb_valid}, 32'd0);
    chk("reset_wb_rd", {27'b0, bus.wb_rd}, 32'd0);
    chk("reset_wb_data", bus.wb_data, 32'd0);
    #1 rst = 1'b0;
    mon_en = 1'b1;

    // Single DIVU 100/7 rd=5: tag walks through every stage
    issue(1'b0, 1'b0, 5'd5, 32'd100, 32'd7, 32'd14);
    @(posedge clk); #1;
    bus.issue_valid = 1'b0;
    for (int k = 0; k < 8; k++) begin
      if (k > 0) begin @(posedge clk); #1; end
      chk($sformatf("walk_busy%0d", k), {25'b0, busy[k]}, 32'h45);
      ntag = 0;
      for (int j = 0; j < 8; j++) ntag += int'(busy[j][6]);
      chk($sformatf("walk_ntags%0d", k), ntag, 32'd1);
    end
    drain();

    // Table vectors, issued back-to-back
    for (int i = 0; i < 15; i++)
      issue(tbl[i].sgn, tbl[i].gr, tbl[i].rd, tbl[i].a, tbl[i].b, tbl[i].exp);
    drain();

    // Random ops with occasional bubbles, expected values from the reference model
    for (int i = 0; i < 24; i++) begin
      rs = 1'($urandom_range(0, 1));
      rg = 1'($urandom_range(0, 1));
      ra = $urandom;
      rb = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 5)) : $urandom;
      if ($urandom_range(0, 1) == 1) rb = rb >> $urandom_range(0, 31);
      issue(rs, rg, 5'($urandom_range(0, 31)), ra, rb, ref_div(rs, rg, ra, rb));
      if ($urandom_range(0, 3) == 0) idle();
    end
    drain();

    // Eight in flight: all tags valid at once, rd=8 in stage 0 down to rd=1 in stage 7
    for (int r = 1; r <= 8; r++)
      issue(1'b0, 1'b0, 5'(r), 32'(1000 + r), 32'(r + 1), 32'((1000 + r) / (r + 1)));
    @(posedge clk); #1;
    bus.issue_valid = 1'b0;
    for (int k = 0; k < 8; k++)
      chk($sformatf("full_busy%0d", k), {25'b0, busy[k]}, {25'b0, 1'b1, 1'b0, 5'(8 - k)});
    drain();

    // Issue gap, and two ops at the same rd one cycle apart
    issue(1'b0, 1'b1, 5'd2, 32'd50, 32'd6, 32'd2);
    idle();
    issue(1'b0, 1'b0, 5'd2, 32'd50, 32'd6, 32'd8);
    issue(1'b1, 1'b0, 5'd2, 32'hFFFF_FFCE, 32'd6, 32'hFFFF_FFF8);
    drain();

    // Reset with 3 ops in flight; issue on the reset edge must also be dropped
    issue(1'b0, 1'b0, 5'd1, 32'd10, 32'd3, 32'd3);
    issue(1'b0, 1'b0, 5'd2, 32'd11, 32'd3, 32'd3);
    issue(1'b0, 1'b0, 5'd3, 32'd12, 32'd3, 32'd4);
    @(negedge clk); #1;
    rst                = 1'b1;
    bus.issue_valid    = 1'b1;
    bus.issue_rd       = 5'd9;
    sb.delete();
    @(posedge clk); #1;
    rst             = 1'b0;
    bus.issue_valid = 1'b0;
    for (int k = 0; k < 8; k++) chk($sformatf("flush_busy%0d", k), {25'b0, busy[k]}, 32'd0);
    for (int n = 0; n < 10; n++) begin
      @(negedge clk); #1;
      chk($sformatf("flush_wb%0d", n), {31'b0, bus.wb_valid}, 32'd0);
    end
    issue(1'b1, 1'b1, 5'd17, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFFE);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global time bound so the run always terminates
  initial begin
    #200000;
    $display("FAIL timeout: got no completion expected finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/div_pipe8.md
# div_pipe8

Fully pipelined 8-stage integer divider for RV32M DIV/DIVU/REM/REMU, sitting beside the ALU in execute. It accepts one divide per cycle from the decode/execute register and retires each result exactly 8 cycles later to writeback. Every stage exports a 7-bit busy tag; decode uses these tags for RAW stalls and for writeback-collision stalls.

## Interface
Parameters:
- XLEN, 32: operand width. Must equal 8 × BITS_PER_STAGE.
- BITS_PER_STAGE, 4: quotient bits resolved per stage (unrolled restoring iterations).

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- issue_valid  in  1  new divide op this cycle (decode's registered div-op flag)
- issue_signed  in  1  1 = DIV/REM, 0 = DIVU/REMU
- issue_get_rem  in  1  1 = return remainder, 0 = quotient
- issue_rd  in  5  destination register
- issue_dividend  in  XLEN  rs1 value, already forwarded
- issue_divisor  in  XLEN  rs2 value, already forwarded
- div_busy_0 … div_busy_7  out  7 each  stage tag: [6] valid, [5] get_rem, [4:0] rd
- wb_valid  out  1  result valid this cycle (equals div_busy_7[6])
- wb_rd  out  5  destination of result
- wb_data  out  XLEN  final signed-corrected result

## Operation
- No handshake back-pressure: the divider is never busy. Decode guarantees ordering and collisions.
- Issue: on an edge with issue_valid=1, stage 0 captures:
  - sign-stripped magnitudes |a| and |b| (magnitudes only when issue_signed=1);
  - neg_q = signed & (a[31]^b[31]) & (b≠0);
  - neg_r = signed & a[31];
  - div0 = (b==0);
  - get_rem and rd;
  - the partial remainder and quotient after the first 4 restoring iterations.
- Stage k (1..7) takes stage k−1, performs 4 more iterations (shift remainder left with the next dividend bit, trial-subtract |b|, set q bit if no borrow), and registers the result. The valid bit and all metadata travel with the data.
- Stage 7 holds the complete magnitude quotient and remainder. wb_data is combinational from stage 7:
  - quotient: div0 → 0xFFFFFFFF; else neg_q ? −q : q.
  - remainder: neg_r ? −r : r.
  - get_rem selects between the two.
- Corner cases follow from the magnitude datapath with no extra logic beyond div0:
  - overflow: −2^31 / −1 → quotient 0x80000000, remainder 0;
  - div-by-zero remainder = dividend.
- Busy tag k = stage k valid ? {1, get_rem, rd} : 7'b0. Tags with rd=0 are still marked valid; the consumer filters rd=0.
- Stage registers have no enable: an invalid bubble advances like a valid op.

## Timing
- Reset: all stage valid bits 0. All div_busy_k = 0, wb_valid = 0, wb_rd = 0, wb_data = 0 (outputs gated by valid).
- Latency: issue sampled at edge E0 appears in div_busy_0 after E0. It occupies div_busy_k after edge E0+k, and wb_valid is 1 for exactly the cycle after E0+7.
- Throughput: 1 op per cycle. 8 ops in flight show all 8 tags valid simultaneously.
- Back-to-back issue at the same rd: both tags coexist; they retire in issue order, one cycle apart.
- rst mid-operation: all in-flight ops are discarded at the next edge. No wb_valid pulse follows.
- rst and issue_valid on the same edge: rst wins and stage 0 stays invalid.
- No flush input: ops already issued always complete, because decode squashes wrong-path ops before issue.

## Structure
- Shared package/params header holds:
  - BUSY_VALID_BIT = 6, BUSY_REM_BIT = 5, BUSY_RD_MSB/LSB = 4/0;
  - stage count DIV_STAGES = 8;
  - the stage record layout: valid, get_rem, neg_q, neg_r, div0, rd, rem[XLEN], quo[XLEN], divisor[XLEN], remaining dividend bits.
- One sub-module, div_stage_step: combinational 4-iteration restoring step (rem, quo, dividend bits, divisor in → updated values out). It is instantiated 8 times: once on the issue path and once per stage 1..7.

## Test plan
- DIVU 100 / 7, rd=5, issued at E0 → div_busy_0..7 show 7'h45 on successive cycles; wb_valid=1, wb_rd=5, wb_data=14 in the cycle after E0+7. Same op as REMU → wb_data=2.
- DIV −7 / 2 → quotient 0xFFFFFFFD (−3). REM −7 / 2 → remainder 0xFFFFFFFF (−1). REM 7 / −2 → remainder 1.
- DIV 0x80000000 / 0xFFFFFFFF → 0x80000000. REM of the same operands → 0.
- DIVU 123 / 0 → 0xFFFFFFFF. REMU 123 / 0 → 123. DIV −5 / 0 → 0xFFFFFFFF. REM −5 / 0 → 0xFFFFFFFB.
- 8 consecutive issues with rd=1..8 → all 8 tags valid in one cycle; results retire in order on 8 consecutive cycles. A one-cycle gap in issue → wb_valid=0 in the corresponding cycle.
- 3 ops in flight, rst asserted for one cycle → all tags 0 after that edge; no wb_valid for 10 cycles; the next issue then completes normally.
